// File: rtl/seq_sub64_pkg.sv
// rtl/seq_sub64_pkg.sv - shared FSM state type and default sizing for seq_sub64
package seq_sub64_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_CHUNK  = 16;
    localparam int DEF_NCHUNK = DEF_WIDTH / DEF_CHUNK;
    localparam int IDX_W      = (DEF_NCHUNK > 1) ? $clog2(DEF_NCHUNK) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_sub64_sub_chunk.sv
// rtl/seq_sub64_sub_chunk.sv - combinational W-bit ripple subtractor (x - y - bi) from full-adder cells
module sub_chunk #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bi,
    output logic [W-1:0] d,
    output logic         bo
);

    logic c;

    // x + ~y + ~bi through a full-adder chain; borrow-out is the inverted final carry
    always_comb begin
        d = '0;
        c = ~bi;
        for (int i = 0; i < W; i++) begin
            d[i] = x[i] ^ ~y[i] ^ c;
            c    = (x[i] & ~y[i]) | (c & (x[i] ^ ~y[i]));
        end
        bo = ~c;
    end

endmodule

// File: rtl/seq_sub64.sv
// rtl/seq_sub64.sv - multi-cycle subtractor, one CHUNK slice per clock; SEQ_SUB64_OVF_EN adds signed overflow output ovf
module seq_sub64
    import seq_sub64_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SEQ_SUB64_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    state_t           state, next_state;
    logic             accept;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic             brw_q, bout_q;
    logic [IDXW-1:0]  idx_q;
    logic [CHUNK-1:0] slice_d;
    logic             slice_bo;

    // single shared slice subtractor, fed by the slice selected by idx
    sub_chunk #(.W(CHUNK)) u_sub_chunk (
        .x  (a_q[idx_q*CHUNK +: CHUNK]),
        .y  (b_q[idx_q*CHUNK +: CHUNK]),
        .bi (brw_q),
        .d  (slice_d),
        .bo (slice_bo)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // next-state and status outputs; start is only honoured in IDLE or DONE
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (idx_q == LAST) next_state = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = ST_RUN;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // operand capture on accept, then one slice result and borrow per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            brw_q  <= 1'b0;
            idx_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            brw_q <= bin;
            idx_q <= '0;
        end else if (state == ST_RUN) begin
            diff_q[idx_q*CHUNK +: CHUNK] <= slice_d;
            brw_q <= slice_bo;
            idx_q <= idx_q + 1'b1;
            if (idx_q == LAST) bout_q <= slice_bo;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

`ifdef SEQ_SUB64_OVF_EN
    logic ovf_q;

    // signed overflow: operand signs differ and the result sign departs from the minuend
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state == ST_RUN && idx_q == LAST) begin
            ovf_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (slice_d[CHUNK-1] ^ a_q[WIDTH-1]);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_seq_sub64.sv
// tb/tb_seq_sub64.sv - directed and random self-checking bench for seq_sub64
module tb_seq_sub64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] ai, bi;
    logic        bini;
    logic        busy, done, bout;
    logic [63:0] diff;
    logic        ovf;

    int nchecks = 0;
    int nfail   = 0;

    seq_sub64 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (ai),
        .b     (bi),
        .bin   (bini),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SEQ_SUB64_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

`ifndef SEQ_SUB64_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one operation and wait (bounded) for done; leaves the bench in the done cycle
    task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input logic bnv,
                          output logic [63:0] d, output logic bo, output logic ov,
                          output int nbusy, output bit seen);
        ai = av; bi = bv; bini = bnv; start = 1'b1;
        tick();
        start = 1'b0;
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            tick();
        end
        d  = diff;
        bo = bout;
        ov = ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ai = '0; bi = '0; bini = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            nchecks++;
            if ({busy, done, bout, ovf} !== 4'b0000 || diff !== 64'h0) begin
                nfail++;
                $display("FAIL reset_idle cyc=%0d got busy=%b done=%b bout=%b ovf=%b diff=%h exp all zero",
                         i, busy, done, bout, ovf, diff);
            end
        end
    endtask

    task automatic test_slice_borrow();
        logic [63:0] d; logic bo, ov; int nb; bit seen;
        run_op(64'h0000_0000_0001_0000, 64'h1, 1'b0, d, bo, ov, nb, seen);
        nchecks++;
        if (!seen || nb != 4) begin
            nfail++;
            $display("FAIL slice_latency got seen=%0d busy_cycles=%0d exp seen=1 busy_cycles=4", seen, nb);
        end
        nchecks++;
        if (d !== 64'h0000_0000_0000_FFFF || bo !== 1'b0) begin
            nfail++;
            $display("FAIL slice_borrow got diff=%h bout=%b exp diff=000000000000ffff bout=0", d, bo);
        end
        tick();
        nchecks++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== 64'h0000_0000_0000_FFFF) begin
            nfail++;
            $display("FAIL done_pulse_hold got done=%b busy=%b diff=%h exp done=0 busy=0 diff=000000000000ffff",
                     done, busy, diff);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] d; logic bo, ov; int nb; bit seen;
        run_op(64'h0, 64'h1, 1'b0, d, bo, ov, nb, seen);
        nchecks++;
        if (!seen || d !== 64'hFFFF_FFFF_FFFF_FFFF || bo !== 1'b1) begin
            nfail++;
            $display("FAIL wrap_0_minus_1 got seen=%0d diff=%h bout=%b exp diff=ffffffffffffffff bout=1", seen, d, bo);
        end
        tick();
        run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, d, bo, ov, nb, seen);
        nchecks++;
        if (!seen || d !== 64'hFFFF_FFFF_FFFF_FFFF || bo !== 1'b1) begin
            nfail++;
            $display("FAIL equal_bin1 got seen=%0d diff=%h bout=%b exp diff=ffffffffffffffff bout=1", seen, d, bo);
        end
        tick();
        run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, d, bo, ov, nb, seen);
        nchecks++;
        if (!seen || d !== 64'h0 || bo !== 1'b0) begin
            nfail++;
            $display("FAIL equal_bin0 got seen=%0d diff=%h bout=%b exp diff=0 bout=0", seen, d, bo);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int nb;
        bit seen;
        ai = 64'd20; bi = 64'd5; bini = 1'b0; start = 1'b1;
        tick();
        ai = 64'd10; bi = 64'd3;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin seen = 1'b1; break; end
            tick();
        end
        nchecks++;
        if (!seen || diff !== 64'd15 || bout !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_first got seen=%0d diff=%h bout=%b exp diff=f bout=0", seen, diff, bout);
        end
        tick();
        start = 1'b0;
        nchecks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_no_gap got busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin seen = 1'b1; break; end
            if (busy) nb++;
            tick();
        end
        nchecks++;
        if (!seen || nb != 4 || diff !== 64'd7 || bout !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_second got seen=%0d busy_cycles=%0d diff=%h bout=%b exp busy_cycles=4 diff=7 bout=0",
                     seen, nb, diff, bout);
        end
        tick();
    endtask

    task automatic test_start_during_run();
        int nb;
        bit seen;
        ai = 64'd100; bi = 64'd1; bini = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ai = 64'd5; bi = 64'd7; bini = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        nb = 2;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin seen = 1'b1; break; end
            if (busy) nb++;
            tick();
        end
        nchecks++;
        if (!seen || nb != 4 || diff !== 64'd99 || bout !== 1'b0) begin
            nfail++;
            $display("FAIL start_in_run got seen=%0d busy_cycles=%0d diff=%h bout=%b exp busy_cycles=4 diff=63 bout=0",
                     seen, nb, diff, bout);
        end
        tick();
    endtask

    task automatic test_rst_mid_run();
        ai = 64'h0000_0000_0000_0064; bi = 64'h1; bini = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nchecks++;
        if ({busy, done, bout, ovf} !== 4'b0000 || diff !== 64'h0) begin
            nfail++;
            $display("FAIL rst_mid_run got busy=%b done=%b bout=%b ovf=%b diff=%h exp all zero",
                     busy, done, bout, ovf, diff);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            nchecks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                nfail++;
                $display("FAIL rst_no_done cyc=%0d got done=%b busy=%b exp 0 0", i, done, busy);
            end
        end
    endtask

`ifdef SEQ_SUB64_OVF_EN
    task automatic test_ovf();
        logic [63:0] d; logic bo, ov; int nb; bit seen;
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, d, bo, ov, nb, seen);
        nchecks++;
        if (!seen || ov !== 1'b1 || d !== 64'h7FFF_FFFF_FFFF_FFFF || bo !== 1'b0) begin
            nfail++;
            $display("FAIL ovf_min_minus_1 got ovf=%b diff=%h bout=%b exp ovf=1 diff=7fffffffffffffff bout=0", ov, d, bo);
        end
        tick();
        run_op(64'd5, 64'd3, 1'b0, d, bo, ov, nb, seen);
        nchecks++;
        if (!seen || ov !== 1'b0 || d !== 64'd2) begin
            nfail++;
            $display("FAIL ovf_5_minus_3 got ovf=%b diff=%h exp ovf=0 diff=2", ov, d);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [63:0] ra, rb, d;
        logic        rbin, bo, ov;
        logic [64:0] full;
        logic signed [65:0] s;
        logic        exp_ovf;
        int nb;
        bit seen;
        for (int n = 0; n < 1000; n++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            rbin = 1'($urandom_range(0, 1));
            if (n % 8 == 0) rb = ra;
            full = {1'b0, ra} - {1'b0, rb} - 65'(rbin);
            s    = $signed({{2{ra[63]}}, ra}) - $signed({{2{rb[63]}}, rb}) - $signed({65'd0, rbin});
            exp_ovf = !(s[65:63] == 3'b000 || s[65:63] == 3'b111);
            run_op(ra, rb, rbin, d, bo, ov, nb, seen);
            nchecks++;
            if (!seen || nb != 4 || d !== full[63:0] || bo !== full[64]) begin
                nfail++;
                $display("FAIL random n=%0d a=%h b=%h bin=%b got diff=%h bout=%b busy_cycles=%0d exp diff=%h bout=%b",
                         n, ra, rb, rbin, d, bo, nb, full[63:0], full[64]);
            end
`ifdef SEQ_SUB64_OVF_EN
            nchecks++;
            if (ov !== exp_ovf) begin
                nfail++;
                $display("FAIL random_ovf n=%0d a=%h b=%h bin=%b got ovf=%b exp %b", n, ra, rb, rbin, ov, exp_ovf);
            end
`else
            if (ov !== 1'b0 && exp_ovf === 1'bx) nfail = nfail;
`endif
            if (n % 3 == 0) tick();
        end
    endtask

    initial begin
        test_reset();
        test_slice_borrow();
        test_wrap();
        test_back_to_back();
        test_start_during_run();
        test_rst_mid_run();
`ifdef SEQ_SUB64_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
